// File: rtl/eq_pipe_pkg.sv
// eq_pipe_pkg: shared width default, result-width derivation and stage-valid type for eq_pipe_hs
package eq_pipe_pkg;
  localparam int W_DEF = 8;
  typedef logic [2:0] valid_t;
  function automatic int ow_f(input int w);
    return 2 * w + 1;
  endfunction
endpackage

// File: rtl/eq_pipe_stage.sv
// eq_pipe_stage: one pipeline slot (valid bit + data) with load enable, flush and async active-low reset
module eq_pipe_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          flush,
  input  logic          vin,
  input  logic [DW-1:0] din,
  output logic          vout,
  output logic [DW-1:0] dout
);
  // load on enable; flush clears the valid bit even while the pipe is frozen
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      vout <= 1'b0;
      dout <= '0;
    end else begin
      if (en) begin
        vout <= vin;
        dout <= din;
      end
      if (flush) vout <= 1'b0;
    end
endmodule

// File: rtl/eq_pipe_hs.sv
// eq_pipe_hs: 3-stage handshaked E = A*B + C*C + OFFSET pipeline; EQ_PIPE_STAGE_TAP_EN adds stage debug taps
module eq_pipe_hs
  import eq_pipe_pkg::*;
#(
  parameter int          W      = W_DEF,
  parameter int unsigned OFFSET = 0,
  localparam int         OW     = ow_f(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  A,
  input  logic [W-1:0]  B,
  input  logic [W-1:0]  C,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] E
`ifdef EQ_PIPE_STAGE_TAP_EN
  ,
  output logic [2*W-1:0] s1,
  output logic [OW-1:0]  s2,
  output logic [OW-1:0]  s3,
  output valid_t         tap_valid
`endif
);
  localparam logic [OW-1:0] OFF = OW'(OFFSET);
  logic v1, v2, v3, adv1, adv2, adv3;
  logic [2*W-1:0] p1, p2, p1_q, p2_q;
  logic [OW-1:0] s, s_q;
  valid_t v;
  assign v = {v3, v2, v1};
  // bubbles collapse: a stage moves whenever it is empty or the one ahead moves
  assign adv3 = out_ready | ~v[2];
  assign adv2 = ~v[1] | adv3;
  assign adv1 = ~v[0] | adv2;
  assign in_ready = ~stall & adv1;
  assign out_valid = v[2];
  assign p1 = {{W{1'b0}}, A} * {{W{1'b0}}, B};
  assign p2 = {{W{1'b0}}, C} * {{W{1'b0}}, C};
  assign s = {1'b0, p1_q} + {1'b0, p2_q};
  eq_pipe_stage #(.DW(4*W)) u_st1 (
    .clk(clk), .rst(rst), .en(adv1 & ~stall), .flush(flush),
    .vin(in_valid), .din({p1, p2}), .vout(v1), .dout({p1_q, p2_q})
  );
  eq_pipe_stage #(.DW(OW)) u_st2 (
    .clk(clk), .rst(rst), .en(adv2 & ~stall), .flush(flush),
    .vin(v1), .din(s), .vout(v2), .dout(s_q)
  );
  eq_pipe_stage #(.DW(OW)) u_st3 (
    .clk(clk), .rst(rst), .en(adv3 & ~stall), .flush(flush),
    .vin(v2), .din(s_q + OFF), .vout(v3), .dout(E)
  );
`ifdef EQ_PIPE_STAGE_TAP_EN
  assign s1 = p1_q;
  assign s2 = s_q;
  assign s3 = E;
  assign tap_valid = v;
`endif
endmodule
